freq_meter_50mhz: RTL and testbench

Gated frequency meter for the 50 MHz board clock domain. Counts rising edges of an external or asynchronous signal over a fixed gate window derived from `clock50` (1 s by default), then reports the count in hertz. It sits beside the 50 MHz to 1 Hz divider: the divider produces slow clocks, and this block measures them. It is also used to check the divider and other slow sources on the board.

---
 rtl/freq_meter_pkg.sv | 6 +
 rtl/sig_edge_detect.sv | 26 ++
 rtl/freq_meter_50mhz.sv | 67 ++++++
 tb/tb_freq_meter_50mhz.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared state encoding and default sizing for the gated frequency meter
package freq_meter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GATE = 2'd1, DONE = 2'd2} fm_state_t;
  localparam int FM_GATE_1S = 50000000;
  localparam int FM_CNT_W_DEFAULT = 26;
endpackage

// File: rtl/sig_edge_detect.sv
// sig_edge_detect: rising-edge detector on sig_in, with a 2-flop synchronizer when FREQ_METER_SYNC_EN is defined
module sig_edge_detect (
  input  logic clock50,
  input  logic reset,
  input  logic sig_in,
  output logic rise
);
`ifdef FREQ_METER_SYNC_EN
  logic [1:0] sync;
  logic hist;
  always_ff @(posedge clock50)
    if (reset) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[0], sig_in};
      hist <= sync[1];
    end
  assign rise = sync[1] & ~hist;
`else
  logic hist;
  always_ff @(posedge clock50)
    hist <= reset ? 1'b0 : sig_in;
  assign rise = sig_in & ~hist;
`endif
endmodule

// File: rtl/freq_meter_50mhz.sv
// freq_meter_50mhz: counts sig_in rising edges over a GATE_CYCLES window of clock50 and reports the count
// Build option: define FREQ_METER_SYNC_EN to synchronize an asynchronous sig_in.
module freq_meter_50mhz
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = FM_GATE_1S,
  parameter int CNT_W = FM_CNT_W_DEFAULT
) (
  input  logic             clock50,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] freq,
  output logic             overflow
);
  localparam int GW = GATE_CYCLES > 1 ? $clog2(GATE_CYCLES) : 1;
  fm_state_t state, state_nx;
  logic [GW-1:0] gate_cnt;
  logic [CNT_W-1:0] edge_cnt, edge_nx;
  logic ovf, ovf_nx, rise, arm, last, sat, clear;
  sig_edge_detect u_edge (
    .clock50(clock50),
    .reset  (reset),
    .sig_in (sig_in),
    .rise   (rise)
  );
  always_comb begin
    arm = start | continuous;
    last = state == GATE && gate_cnt == GW'(GATE_CYCLES - 1);
    sat = &edge_cnt;
    edge_nx = edge_cnt + CNT_W'(rise & ~sat);
    ovf_nx = ovf | (rise & sat);
    state_nx = state == IDLE ? (arm ? GATE : IDLE) :
               state == GATE ? (last ? DONE : GATE) :
               (arm ? GATE : IDLE);
    clear = state_nx == GATE && state != GATE;
  end
  always_ff @(posedge clock50)
    if (reset) begin
      state <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf <= 1'b0;
      freq <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (clear) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        ovf <= 1'b0;
      end else if (state == GATE) begin
        gate_cnt <= gate_cnt + GW'(1);
        edge_cnt <= edge_nx;
        ovf <= ovf_nx;
      end
      if (last) begin
        freq <= edge_nx;
        overflow <= ovf_nx;
      end
    end
  assign busy = state == GATE || state == DONE;
  assign valid = state == DONE;
endmodule

// File: tb/tb_freq_meter_50mhz.sv
// tb_freq_meter_50mhz: directed/random checks of two meter instances (8-bit and 4-bit counters) against an edge-window model
module tb_freq_meter_50mhz;
  localparam int G = 100;
`ifdef FREQ_METER_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif
  logic clock50 = 1'b0, reset = 1'b1, sig_in = 1'b0, start = 1'b0, continuous = 1'b0;
  logic busy8, valid8, ovf8, busy4, valid4, ovf4;
  logic [7:0] freq8;
  logic [3:0] freq4;
  int cyc = 0, mode = 0, per = 10, total = 0, passed = 0, fails = 0;
  bit samp [0:8191];
  always #5 clock50 = ~clock50;
  freq_meter_50mhz #(.GATE_CYCLES(G), .CNT_W(8)) u8 (
    .clock50(clock50), .reset(reset), .sig_in(sig_in), .start(start), .continuous(continuous),
    .busy(busy8), .valid(valid8), .freq(freq8), .overflow(ovf8));
  freq_meter_50mhz #(.GATE_CYCLES(G), .CNT_W(4)) u4 (
    .clock50(clock50), .reset(reset), .sig_in(sig_in), .start(start), .continuous(continuous),
    .busy(busy4), .valid(valid4), .freq(freq4), .overflow(ovf4));
  always @(posedge clock50) begin
    samp[cyc] <= sig_in;
    cyc <= cyc + 1;
  end
  // Rises on sig_in as sampled at each edge, shifted by detection delay, counted over the window's edges
  function automatic int count(input int n0);
    int c = 0;
    for (int e = n0 + 1; e <= n0 + G; e++)
      if (e - D >= 1 && samp[e-D] && !samp[e-D-1]) c++;
    return c;
  endfunction
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clock50);
    #1;
    sig_in = mode == 0 ? 1'b0 : mode == 1 ? ((cyc % per) < per / 2) : mode == 2 ? ~sig_in : (($urandom & 1) == 1);
  endtask
  task automatic check_result(input string tag, input int n);
    chk({tag, "_freq8"}, freq8, n > 255 ? 255 : n);
    chk({tag, "_ovf8"}, ovf8, n > 255);
    chk({tag, "_freq4"}, freq4, n > 15 ? 15 : n);
    chk({tag, "_ovf4"}, ovf4, n > 15);
    chk({tag, "_valid4"}, valid4, 1);
  endtask
  task automatic measure(input string tag, input bit pulses, output int n);
    int gn, bc = 0, vc = 0, vj = -1;
    n = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    gn = cyc - 1;
    for (int j = 0; j <= G + 3; j++) begin
      if (j > 0) begin
        start = pulses && (j == 30 || j == 60);
        step();
        start = 1'b0;
      end
      bc += int'(busy8);
      vc += int'(valid8);
      if (valid8) begin
        vj = j;
        n = count(gn);
        check_result(tag, n);
      end
    end
    chk({tag, "_busy_cycles"}, bc, G + 1);
    chk({tag, "_valid_count"}, vc, 1);
    chk({tag, "_valid_cycle"}, vj, G);
    chk({tag, "_idle_after"}, busy8, 0);
  endtask
  initial begin
    int n, bc, vc, last_j, k, gn;
    mode = 0;
    repeat (3) step();
    chk("rst_busy", busy8, 0);
    chk("rst_valid", valid8, 0);
    chk("rst_freq", freq8, 0);
    chk("rst_ovf", ovf8, 0);
    reset = 1'b0;
    mode = 1;
    per = 10;
    repeat (4) step();
    measure("period10", 1'b0, n);
    chk("period10_const", freq8, 10);
    mode = 0;
    repeat (5) step();
    measure("idle_sig", 1'b0, n);
    chk("idle_sig_const", freq8, 0);
    mode = 2;
    measure("toggle", 1'b0, n);
    chk("toggle_const8", freq8, 50);
    repeat (20) step();
    chk("sat_hold_freq4", freq4, 15);
    chk("sat_hold_ovf4", ovf4, 1);
    mode = 3;
    repeat (2) measure("random", 1'b0, n);
    mode = 1;
    per = 10;
    measure("start_ign", 1'b1, n);
    mode = 1;
    per = 20;
    continuous = 1'b1;
    step();
    gn = cyc - 1;
    bc = 0;
    k = 0;
    last_j = -1;
    for (int j = 0; j <= 3 * G + 2; j++) begin
      if (j > 0) step();
      bc += int'(!busy8);
      if (valid8) begin
        n = count(gn + k * (G + 1));
        check_result("cont", n);
        chk("cont_range", int'(freq8 >= 4 && freq8 <= 6), 1);
        if (k > 0) chk("cont_interval", j - last_j, G + 1);
        last_j = j;
        k++;
        if (k == 3) continuous = 1'b0;
      end
    end
    chk("cont_results", k, 3);
    chk("cont_busy_low", bc, 0);
    step();
    chk("cont_stop", busy8, 0);
    per = 10;
    measure("pre_reset", 1'b0, n);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (50) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy", busy8, 0);
    chk("midrst_valid", valid8, 0);
    chk("midrst_freq8", freq8, 0);
    chk("midrst_freq4", freq4, 0);
    vc = 0;
    bc = 0;
    repeat (200) begin
      step();
      vc += int'(valid8 | valid4);
      bc += int'(busy8 | busy4);
    end
    chk("midrst_no_valid", vc, 0);
    chk("midrst_no_busy", bc, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
